// File: rtl/data_mem_ctrl.sv
// MEM-stage initiator for the single-port data RAM: byte/half/word loads and stores,
// with read-modify-write for sub-word stores and a busy/done handshake toward the pipeline.
module data_mem_ctrl #(
    parameter int NB_DEPTH    = 10,
    parameter int RAM_LATENCY = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req,
    input  logic                i_we,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    input  logic [31:0]         i_addr,
    input  logic [31:0]         i_wdata,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [31:0]         o_rdata,
    output logic [NB_DEPTH-1:0] o_ram_addr,
    output logic [31:0]         o_ram_data,
    output logic                o_ram_wea,
    output logic                o_ram_ena,
    output logic                o_ram_regcea,
    output logic                o_ram_rst,
    input  logic [31:0]         i_ram_data
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, CAP, DONE} state_t;

    state_t                state;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [NB_DEPTH+1:0]   r_addr;
    logic [31:0]           r_wdata;

    logic                  req_bad;
    logic                  accept;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [31:0]           load_ext;
    logic [31:0]           merged;

    // Address bits above the RAM's reach are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr[31:NB_DEPTH+2];

    assign o_ram_rst = i_rst;

    always_comb begin
        req_bad = (i_size == 2'b11)
                | ((i_size == 2'b01) && i_addr[0])
                | ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));
        accept  = i_req && ((state == IDLE) || (state == DONE));
    end

    // Lane extraction for loads and lane replacement for read-modify-write stores.
    always_comb begin
        case (r_addr[1:0])
            2'd0:    lane_byte = i_ram_data[7:0];
            2'd1:    lane_byte = i_ram_data[15:8];
            2'd2:    lane_byte = i_ram_data[23:16];
            default: lane_byte = i_ram_data[31:24];
        endcase
        lane_half = r_addr[1] ? i_ram_data[31:16] : i_ram_data[15:0];

        case (r_size)
            2'b00:   load_ext = r_unsigned ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = r_unsigned ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_ext = i_ram_data;
        endcase

        merged = i_ram_data;
        if (r_size == 2'b00)
            merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else if (r_size == 2'b01)
            merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    always_comb begin
        o_ram_ena    = 1'b0;
        o_ram_wea    = 1'b0;
        o_ram_regcea = 1'b0;
        o_ram_addr   = '0;
        o_ram_data   = '0;
        case (state)
            RD: begin
                o_ram_ena  = 1'b1;
                o_ram_addr = r_addr[NB_DEPTH+1:2];
            end
            WAIT: begin
                o_ram_ena    = 1'b1;
                o_ram_regcea = 1'b1;
                o_ram_addr   = r_addr[NB_DEPTH+1:2];
            end
            WR: begin
                o_ram_ena  = 1'b1;
                o_ram_wea  = 1'b1;
                o_ram_addr = r_addr[NB_DEPTH+1:2];
                o_ram_data = (r_size == 2'b10) ? r_wdata : merged;
            end
            default: ;
        endcase
    end

    // Request FSM; o_busy/o_done/o_err are registered alongside each state transition.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_rdata    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    o_done <= 1'b0;
                    o_err  <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                    if (accept) begin
                        r_we       <= i_we;
                        r_size     <= i_size;
                        r_unsigned <= i_unsigned;
                        r_addr     <= i_addr[NB_DEPTH+1:0];
                        r_wdata    <= i_wdata;
                        if (req_bad) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                            o_err  <= 1'b1;
                        end else if (i_we && (i_size == 2'b10)) begin
                            state  <= WR;
                            o_busy <= 1'b1;
                        end else begin
                            state  <= RD;
                            o_busy <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (RAM_LATENCY == 2)
                        state <= WAIT;
                    else
                        state <= r_we ? WR : CAP;
                end
                WAIT: state <= r_we ? WR : CAP;
                WR: begin
                    state  <= DONE;
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end
                CAP: begin
                    o_rdata <= load_ext;
                    state   <= DONE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance at RAM_LATENCY 1 and one at 2, each with its own RAM model.
module tb_data_mem_ctrl;

    localparam int NB_DEPTH = 10;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, sel, we, uns, init_mem;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        req1, req2;
    assign req1 = req & ~sel;
    assign req2 = req & sel;

    logic                busy1, done1, err1, wea1, ena1, reg1, ramrst1;
    logic [31:0]         rdata1, ram_data1, ram_in1;
    logic [NB_DEPTH-1:0] ram_addr1;
    logic                busy2, done2, err2, wea2, ena2, reg2, ramrst2;
    logic [31:0]         rdata2, ram_data2, ram_in2, ram_q2;
    logic [NB_DEPTH-1:0] ram_addr2;

    data_mem_ctrl #(.NB_DEPTH(NB_DEPTH), .RAM_LATENCY(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req1), .i_we(we), .i_size(size),
        .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
        .o_busy(busy1), .o_done(done1), .o_err(err1), .o_rdata(rdata1),
        .o_ram_addr(ram_addr1), .o_ram_data(ram_data1), .o_ram_wea(wea1),
        .o_ram_ena(ena1), .o_ram_regcea(reg1), .o_ram_rst(ramrst1),
        .i_ram_data(ram_in1)
    );

    data_mem_ctrl #(.NB_DEPTH(NB_DEPTH), .RAM_LATENCY(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_req(req2), .i_we(we), .i_size(size),
        .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
        .o_busy(busy2), .o_done(done2), .o_err(err2), .o_rdata(rdata2),
        .o_ram_addr(ram_addr2), .o_ram_data(ram_data2), .o_ram_wea(wea2),
        .o_ram_ena(ena2), .o_ram_regcea(reg2), .o_ram_rst(ramrst2),
        .i_ram_data(ram_in2)
    );

    // Single-port RAM models: latency 1 (no output register) and latency 2 (output register).
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem2 [0:1023];

    always @(posedge clk) begin
        if (init_mem) begin
            mem1[5] <= 32'h80818283;
            mem1[8] <= 32'h0;
        end else if (ena1) begin
            if (wea1) mem1[ram_addr1] <= ram_data1;
            ram_in1 <= mem1[ram_addr1];
        end
    end

    always @(posedge clk) begin
        if (init_mem) begin
            mem2[3] <= 32'h11223344;
        end else begin
            if (ena2) begin
                if (wea2) mem2[ram_addr2] <= ram_data2;
                ram_q2 <= mem2[ram_addr2];
            end
            if (reg2) ram_in2 <= ram_q2;
        end
    end

    logic        s_busy, s_done, s_err, s_wea, s_ena, s_reg;
    logic [31:0] s_rdata, s_ram_data, s_ram_addr;
    assign s_busy     = sel ? busy2 : busy1;
    assign s_done     = sel ? done2 : done1;
    assign s_err      = sel ? err2 : err1;
    assign s_wea      = sel ? wea2 : wea1;
    assign s_ena      = sel ? ena2 : ena1;
    assign s_reg      = sel ? reg2 : reg1;
    assign s_rdata    = sel ? rdata2 : rdata1;
    assign s_ram_data = sel ? ram_data2 : ram_data1;
    assign s_ram_addr = sel ? 32'(ram_addr2) : 32'(ram_addr1);

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_ena;
        int          exp_wea;
        int          exp_reg;
    } vec_t;

    vec_t        vecs1 [18];
    vec_t        vecs2 [4];
    logic [31:0] last_rdata [2];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee,
                                input int lat, input int ne, input int nw, input int nr);
        vec_t v;
        v.we = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
        v.exp_ena = ne; v.exp_wea = nw; v.exp_reg = nr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, 32'(s_busy), 32'd0);
        checkOutput({tag, " done"}, 32'(s_done), 32'd0);
        checkOutput({tag, " err"}, 32'(s_err), 32'd0);
        checkOutput({tag, " rdata"}, s_rdata, 32'd0);
        checkOutput({tag, " ram_addr"}, s_ram_addr, 32'd0);
        checkOutput({tag, " ram_data"}, s_ram_data, 32'd0);
        checkOutput({tag, " ena"}, 32'(s_ena), 32'd0);
        checkOutput({tag, " wea"}, 32'(s_wea), 32'd0);
        checkOutput({tag, " regcea"}, 32'(s_reg), 32'd0);
    endtask

    // Issue one request on the selected DUT, follow it to o_done and check the whole transaction.
    task automatic applyStimulus(input vec_t v, input string tag);
        int          lat, n_ena, n_wea, n_reg, wea_at, reg_at;
        logic [31:0] ena_addr, exp_rd;
        logic        got;
        @(negedge clk);
        we = v.we; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata; req = 1'b1;
        @(posedge clk);
        lat = 1; n_ena = 0; n_wea = 0; n_reg = 0; wea_at = 0; reg_at = 0;
        ena_addr = 32'hFFFFFFFF; got = 1'b0;
        while (lat <= 20) begin
            @(negedge clk);
            req = 1'b0;
            if (s_ena) begin
                if (n_ena == 0) ena_addr = s_ram_addr;
                n_ena++;
            end
            if (s_wea) begin n_wea++; wea_at = lat; end
            if (s_reg) begin n_reg++; reg_at = lat; end
            if (s_done) begin got = 1'b1; break; end
            @(posedge clk);
            lat++;
        end
        req = 1'b0;
        if (!got) lat = 99;
        exp_rd = (v.we || v.exp_err) ? last_rdata[int'(sel)] : v.exp_rdata;
        if (!v.we && !v.exp_err) last_rdata[int'(sel)] = v.exp_rdata;
        checkOutput({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        checkOutput({tag, " err"}, 32'(s_err), 32'(v.exp_err));
        checkOutput({tag, " rdata"}, s_rdata, exp_rd);
        checkOutput({tag, " busy at done"}, 32'(s_busy), 32'd0);
        checkOutput({tag, " ena cycles"}, 32'(n_ena), 32'(v.exp_ena));
        checkOutput({tag, " wea cycles"}, 32'(n_wea), 32'(v.exp_wea));
        checkOutput({tag, " regcea cycles"}, 32'(n_reg), 32'(v.exp_reg));
        if (v.exp_wea > 0) checkOutput({tag, " wea cycle"}, 32'(wea_at), 32'(v.exp_lat - 1));
        if (v.exp_reg > 0) checkOutput({tag, " regcea cycle"}, 32'(reg_at), 32'd2);
        if (v.exp_ena > 0) checkOutput({tag, " ram addr"}, ena_addr, {22'h0, v.addr[11:2]});
    endtask

    initial begin
        int n_wea, n_done;

        //              we  size   u   addr          wdata         rdata         err lat ena wea reg
        vecs1[0]  = mk(0, 2'b10, 0, 32'h14, 32'h0,        32'h80818283, 0, 3, 1, 0, 0);
        vecs1[1]  = mk(0, 2'b00, 0, 32'h15, 32'h0,        32'hFFFFFF82, 0, 3, 1, 0, 0);
        vecs1[2]  = mk(0, 2'b00, 1, 32'h15, 32'h0,        32'h00000082, 0, 3, 1, 0, 0);
        vecs1[3]  = mk(0, 2'b01, 0, 32'h16, 32'h0,        32'hFFFF8081, 0, 3, 1, 0, 0);
        vecs1[4]  = mk(0, 2'b01, 1, 32'h14, 32'h0,        32'h00008283, 0, 3, 1, 0, 0);
        vecs1[5]  = mk(0, 2'b00, 0, 32'h14, 32'h0,        32'hFFFFFF83, 0, 3, 1, 0, 0);
        vecs1[6]  = mk(0, 2'b10, 0, 32'h16, 32'h0,        32'h0,        1, 1, 0, 0, 0);
        vecs1[7]  = mk(0, 2'b01, 0, 32'h15, 32'h0,        32'h0,        1, 1, 0, 0, 0);
        vecs1[8]  = mk(1, 2'b11, 0, 32'h14, 32'h5A5A5A5A, 32'h0,        1, 1, 0, 0, 0);
        vecs1[9]  = mk(1, 2'b00, 0, 32'h17, 32'h000000AA, 32'h0,        0, 3, 2, 1, 0);
        vecs1[10] = mk(0, 2'b10, 0, 32'h14, 32'h0,        32'hAA818283, 0, 3, 1, 0, 0);
        vecs1[11] = mk(1, 2'b01, 0, 32'h14, 32'hFFFF1234, 32'h0,        0, 3, 2, 1, 0);
        vecs1[12] = mk(0, 2'b10, 0, 32'h14, 32'h0,        32'hAA811234, 0, 3, 1, 0, 0);
        vecs1[13] = mk(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 32'h0,        0, 2, 1, 1, 0);
        vecs1[14] = mk(0, 2'b10, 0, 32'h20, 32'h0,        32'hDEADBEEF, 0, 3, 1, 0, 0);
        vecs1[15] = mk(0, 2'b00, 0, 32'h17, 32'h0,        32'hFFFFFFAA, 0, 3, 1, 0, 0);
        vecs1[16] = mk(1, 2'b00, 0, 32'h16, 32'h00000177, 32'h0,        0, 3, 2, 1, 0);
        vecs1[17] = mk(0, 2'b01, 1, 32'h16, 32'h0,        32'h0000AA77, 0, 3, 1, 0, 0);

        vecs2[0]  = mk(0, 2'b10, 0, 32'h0C, 32'h0,        32'h11223344, 0, 4, 2, 0, 1);
        vecs2[1]  = mk(0, 2'b00, 1, 32'h0E, 32'h0,        32'h00000022, 0, 4, 2, 0, 1);
        vecs2[2]  = mk(1, 2'b00, 0, 32'h0C, 32'h00000055, 32'h0,        0, 4, 3, 1, 1);
        vecs2[3]  = mk(0, 2'b00, 0, 32'h0F, 32'h0,        32'h00000011, 0, 4, 2, 0, 1);

        rst = 1'b1; init_mem = 1'b1; req = 1'b0; sel = 1'b0;
        we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
        last_rdata[0] = '0; last_rdata[1] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 1'b0; checkAllZero("reset lat1");
        checkOutput("ram_rst follows reset", 32'(ramrst1), 32'd1);
        sel = 1'b1; checkAllZero("reset lat2");
        rst = 1'b0; init_mem = 1'b0;

        sel = 1'b0;
        for (int i = 0; i < 18; i++) applyStimulus(vecs1[i], $sformatf("lat1 vec%0d", i));

        // Back-to-back: second load is held high through busy and accepted in the DONE cycle.
        @(negedge clk);
        we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h14; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        addr = 32'h20;
        checkOutput("b2b first busy", 32'(s_busy), 32'd1);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        checkOutput("b2b first done", 32'(s_done), 32'd1);
        checkOutput("b2b first rdata", s_rdata, 32'hAA771234);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        checkOutput("b2b second started", 32'(s_busy), 32'd1);
        checkOutput("b2b second ena", 32'(s_ena), 32'd1);
        checkOutput("b2b second addr", s_ram_addr, 32'd8);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        checkOutput("b2b second done", 32'(s_done), 32'd1);
        checkOutput("b2b second rdata", s_rdata, 32'hDEADBEEF);

        sel = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(vecs2[i], $sformatf("lat2 vec%0d", i));
        checkOutput("lat2 rmw ram word", mem2[3], 32'h11223355);

        // Reset while a byte store sits in WAIT: nothing may be written and no done pulse appears.
        @(negedge clk);
        we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h0D; wdata = 32'h99; req = 1'b1;
        n_wea = 0; n_done = 0;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        if (s_wea) n_wea++;
        if (s_done) n_done++;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort in wait regcea", 32'(s_reg), 32'd1);
        if (s_wea) n_wea++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("after abort");
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (s_wea) n_wea++;
            if (s_done) n_done++;
        end
        checkOutput("abort wea count", 32'(n_wea), 32'd0);
        checkOutput("abort done count", 32'(n_done), 32'd0);
        checkOutput("abort ram word", mem2[3], 32'h11223355);
        last_rdata[0] = '0; last_rdata[1] = '0;
        applyStimulus(mk(0, 2'b01, 0, 32'h0C, 32'h0, 32'h00003355, 0, 4, 2, 0, 1), "after abort load");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
